cpu2fpga_rd_engine: RTL and testbench

- Host-to-FPGA counterpart of the fpga2cpu write path.
- Fetches 64-byte flits from a host ring buffer using Avalon-MM burst reads on the pcie_bas master port.
- Buffers the returned flits in an internal FIFO and streams them to the FPGA datapath with valid/ready.
- Software publishes the tail pointer. The block reports a head pointer so the CPU can reclaim ring space.

---
 rtl/cpu2fpga_rd_engine_if.sv | 33 +++
 rtl/cpu2fpga_rd_engine.sv | 131 +++++++++++++
 tb/tb_cpu2fpga_rd_engine.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu2fpga_rd_engine_if.sv
// Bus bundle for cpu2fpga_rd_engine: the Avalon-MM burst-read master port toward the
// host and the flit stream toward the FPGA datapath.
interface cpu2fpga_rd_engine_if;
    // Avalon side: a command is accepted on a clock edge where read=1 and waitrequest=0;
    // address/burstcount/read stay stable until then. Each readdatavalid is one beat.
    // Stream side: a flit transfers on a clock edge where out_valid=1 and out_ready=1;
    // out_data stays stable while out_valid=1 and out_ready=0.
    logic         pcie_bas_waitrequest;
    logic [63:0]  pcie_bas_address;
    logic         pcie_bas_read;
    logic [3:0]   pcie_bas_burstcount;
    logic [63:0]  pcie_bas_byteenable;
    logic [511:0] pcie_bas_readdata;
    logic         pcie_bas_readdatavalid;
    logic [1:0]   pcie_bas_response;
    logic [511:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        input  pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
               pcie_bas_response, out_ready,
        output pcie_bas_address, pcie_bas_read, pcie_bas_burstcount,
               pcie_bas_byteenable, out_data, out_valid
    );

    modport slave (
        output pcie_bas_waitrequest, pcie_bas_readdata, pcie_bas_readdatavalid,
               pcie_bas_response, out_ready,
        input  pcie_bas_address, pcie_bas_read, pcie_bas_burstcount,
               pcie_bas_byteenable, out_data, out_valid
    );
endinterface

// File: rtl/cpu2fpga_rd_engine.sv
// Host ring-buffer reader: issues Avalon burst reads between rd_ptr and the software tail,
// buffers returned flits in a show-ahead FIFO and streams them out with valid/ready.
module cpu2fpga_rd_engine #(
    parameter int BUF_SIZE   = 128,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int PTR_W      = $clog2(BUF_SIZE)
) (
    input  logic             pcie_clk,
    input  logic             pcie_reset_n,
    input  logic             cfg_valid,
    input  logic [63:0]      cfg_base,
    input  logic             tail_wr_valid,
    input  logic [PTR_W-1:0] tail_wr_ptr,
    output logic [PTR_W-1:0] head_ptr,
    output logic [31:0]      rd_err_cnt,
    output logic [1:0]       state_dbg,
    cpu2fpga_rd_engine_if.master bus
);
    localparam int FIDX_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = FIDX_W + 1;
    localparam int SUM_W  = CNT_W + PTR_W + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, REQ = 2'd2} state_t;
    state_t state, state_nxt;

    logic [63:0]       base;
    logic [PTR_W-1:0]  rd_ptr, tail, head;
    logic [CNT_W-1:0]  outstanding, fifo_count;
    logic [FIDX_W-1:0] wr_idx, rd_idx;
    logic [511:0]      mem [FIFO_DEPTH];
    logic [63:0]       address;
    logic [3:0]        burstcount;
    logic [31:0]       err_cnt;

    logic [PTR_W-1:0]  pending;
    logic [PTR_W:0]    to_wrap, len;
    logic              fits, issue, cfg_ok, accept, push, pop, out_valid;

    // Burst length is clipped by the configured maximum, the data available and the ring wrap.
    always_comb begin
        pending = tail - rd_ptr;
        to_wrap = (PTR_W+1)'(BUF_SIZE) - {1'b0, rd_ptr};
        len     = (PTR_W+1)'(MAX_BURST);
        if ({1'b0, pending} < len) len = {1'b0, pending};
        if (to_wrap < len) len = to_wrap;
    end

    // FIFO space is reserved for every beat still in flight, so pushes never overflow.
    assign fits   = (SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(len)) <= SUM_W'(FIFO_DEPTH);
    assign issue  = (pending != '0) && fits;
    assign cfg_ok = cfg_valid && ((state == IDLE) ||
                    ((state == ARB) && (outstanding == '0) && (fifo_count == '0)));
    assign accept = (state == REQ) && !bus.pcie_bas_waitrequest;
    assign push   = bus.pcie_bas_readdatavalid && (state != IDLE);
    assign out_valid = (fifo_count != '0);
    assign pop    = out_valid && bus.out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_ok) state_nxt = ARB;
            ARB:     if (!cfg_ok && issue) state_nxt = REQ;
            REQ:     if (accept) state_nxt = ARB;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pcie_clk or negedge pcie_reset_n) begin
        if (!pcie_reset_n) begin
            base        <= '0;
            rd_ptr      <= '0;
            tail        <= '0;
            head        <= '0;
            err_cnt     <= '0;
            address     <= '0;
            burstcount  <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
        end else begin
            if (cfg_ok) begin
                base    <= cfg_base;
                rd_ptr  <= '0;
                tail    <= '0;
                head    <= '0;
                err_cnt <= '0;
            end else begin
                if (tail_wr_valid) tail <= tail_wr_ptr;
                if (accept) rd_ptr <= rd_ptr + PTR_W'(burstcount);
                if (pop) head <= head + PTR_W'(1);
                if (push && (bus.pcie_bas_response != 2'b00) && (err_cnt != '1))
                    err_cnt <= err_cnt + 32'd1;
            end
            if ((state == ARB) && (state_nxt == REQ)) begin
                address    <= base + (64'(rd_ptr) << 6);
                burstcount <= 4'(len);
            end
            outstanding <= outstanding + (accept ? CNT_W'(burstcount) : '0) - CNT_W'(push);
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            if (push) wr_idx <= wr_idx + FIDX_W'(1);
            if (pop) rd_idx <= rd_idx + FIDX_W'(1);
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (push) mem[wr_idx] <= bus.pcie_bas_readdata;
    end

    assert property (@(posedge pcie_clk) disable iff (!pcie_reset_n)
        !(push && (fifo_count == CNT_W'(FIFO_DEPTH))));

    assign bus.pcie_bas_read       = (state == REQ);
    assign bus.pcie_bas_address    = address;
    assign bus.pcie_bas_burstcount = burstcount;
    assign bus.pcie_bas_byteenable = {64{state == REQ}};
    assign bus.out_valid           = out_valid;
    assign bus.out_data            = out_valid ? mem[rd_idx] : '0;
    assign head_ptr                = head;
    assign rd_err_cnt              = err_cnt;
    assign state_dbg               = state;
endmodule

// File: tb/tb_cpu2fpga_rd_engine.sv
// Bench for cpu2fpga_rd_engine: a host memory model answers burst reads, a scoreboard
// holds expected commands and flits, and a monitor checks the delivered stream.
module tb_cpu2fpga_rd_engine;
  localparam int BUF_SIZE = 128;
  localparam int PTR_W = 7;

  logic pcie_clk = 1'b0;
  logic pcie_reset_n = 1'b1;
  logic cfg_valid = 1'b0;
  logic [63:0] cfg_base = '0;
  logic tail_wr_valid = 1'b0;
  logic [PTR_W-1:0] tail_wr_ptr = '0;
  logic [PTR_W-1:0] head_ptr;
  logic [31:0] rd_err_cnt;
  logic [1:0] state_dbg;

  cpu2fpga_rd_engine_if bus();

  cpu2fpga_rd_engine dut (
    .pcie_clk(pcie_clk),
    .pcie_reset_n(pcie_reset_n),
    .cfg_valid(cfg_valid),
    .cfg_base(cfg_base),
    .tail_wr_valid(tail_wr_valid),
    .tail_wr_ptr(tail_wr_ptr),
    .head_ptr(head_ptr),
    .rd_err_cnt(rd_err_cnt),
    .state_dbg(state_dbg),
    .bus(bus)
  );

  // clock / reset
  always #5 pcie_clk = ~pcie_clk;

  int checks = 0;
  int failures = 0;
  logic [511:0] exp_q[$];
  logic [63:0] exp_addr_q[$];
  int exp_bc_q[$];
  int ret_q[$];
  logic [63:0] cur_base = '0;
  int cur_tail = 0;
  int stall_left = 0;
  bit stalling = 0;
  logic [63:0] hold_addr;
  logic [3:0] hold_bc;
  int err_idx = -1;
  int accepted = 0;
  int acc_beats = 0;
  int popped = 0;
  int max_res = 0;

  function automatic logic [511:0] flit_of(input int idx);
    logic [31:0] t;
    logic [31:0] f;
    t = 32'(idx);
    f = (t * 32'h0101_0101) ^ 32'hC3C3_5A5A;
    return {t, {15{f}}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // host memory model: returns one queued beat per cycle, accepts commands after stalls
  initial begin
    int idx;
    int bc;
    bus.pcie_bas_waitrequest = 1'b0;
    bus.pcie_bas_readdatavalid = 1'b0;
    bus.pcie_bas_readdata = '0;
    bus.pcie_bas_response = 2'b00;
    forever begin
      @(negedge pcie_clk);
      if (ret_q.size() > 0) begin
        idx = ret_q.pop_front();
        bus.pcie_bas_readdatavalid = 1'b1;
        bus.pcie_bas_readdata = flit_of(idx);
        bus.pcie_bas_response = (idx == err_idx) ? 2'b10 : 2'b00;
      end else begin
        bus.pcie_bas_readdatavalid = 1'b0;
        bus.pcie_bas_readdata = '0;
        bus.pcie_bas_response = 2'b00;
      end
      if (pcie_reset_n && bus.pcie_bas_read === 1'b1) begin
        if (stalling) begin
          check("stall_addr", bus.pcie_bas_address, hold_addr);
          check("stall_bc", 64'(bus.pcie_bas_burstcount), 64'(hold_bc));
        end
        if (stall_left > 0) begin
          if (!stalling) begin
            stalling = 1;
            hold_addr = bus.pcie_bas_address;
            hold_bc = bus.pcie_bas_burstcount;
          end
          bus.pcie_bas_waitrequest = 1'b1;
          stall_left--;
        end else begin
          stalling = 0;
          bus.pcie_bas_waitrequest = 1'b0;
          accepted++;
          bc = int'(bus.pcie_bas_burstcount);
          if (exp_addr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected: got addr %0h bc %0d expected no command",
                     bus.pcie_bas_address, bc);
          end else begin
            check("cmd_addr", bus.pcie_bas_address, exp_addr_q.pop_front());
            check("cmd_bc", 64'(bc), 64'(exp_bc_q.pop_front()));
          end
          idx = int'(((bus.pcie_bas_address - cur_base) >> 6) & 64'(BUF_SIZE - 1));
          for (int k = 0; k < bc; k++) ret_q.push_back((idx + k) % BUF_SIZE);
          acc_beats += bc;
          if (acc_beats - popped > max_res) max_res = acc_beats - popped;
        end
      end else begin
        bus.pcie_bas_waitrequest = 1'b0;
      end
    end
  end

  // scoreboard monitor on the output stream
  initial begin
    logic [511:0] e;
    forever begin
      @(negedge pcie_clk);
      if (pcie_reset_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        popped++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL flit_unexpected: got tag %0h expected no flit", bus.out_data[511:480]);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            failures++;
            $display("FAIL flit_data: got tag %0h expected tag %0h", bus.out_data[511:480], e[511:480]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic do_cfg(input logic [63:0] b);
    tick();
    cfg_valid = 1'b1;
    cfg_base = b;
    cur_base = b;
    cur_tail = 0;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic set_tail(input int t);
    for (int i = cur_tail; i != t; i = (i + 1) % BUF_SIZE) exp_q.push_back(flit_of(i));
    cur_tail = t;
    tick();
    tail_wr_valid = 1'b1;
    tail_wr_ptr = PTR_W'(t);
    tick();
    tail_wr_valid = 1'b0;
  endtask

  task automatic exp_cmd(input int idx, input int bc);
    exp_addr_q.push_back(cur_base + 64'(idx) * 64);
    exp_bc_q.push_back(bc);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ret_q.size() != 0) && n < budget) begin
      @(negedge pcie_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: got %0d flits pending after %0d cycles expected 0", name, exp_q.size(), n);
    end
    repeat (3) @(negedge pcie_clk);
  endtask

  task automatic check_zero(input string p);
    check({p, "_read"}, 64'(bus.pcie_bas_read), 0);
    check({p, "_addr"}, bus.pcie_bas_address, 0);
    check({p, "_bc"}, 64'(bus.pcie_bas_burstcount), 0);
    check({p, "_be"}, bus.pcie_bas_byteenable, 0);
    check({p, "_out_valid"}, 64'(bus.out_valid), 0);
    check({p, "_out_data_nz"}, 64'(bus.out_data != '0), 0);
    check({p, "_head"}, 64'(head_ptr), 0);
    check({p, "_err_cnt"}, 64'(rd_err_cnt), 0);
  endtask

  initial begin
    int acc0;
    int n;
    bus.out_ready = 1'b1;
    #2 pcie_reset_n = 1'b0;
    repeat (3) @(posedge pcie_clk);
    #1 check_zero("reset");
    pcie_reset_n = 1'b1;
    repeat (5) @(negedge pcie_clk);
    check("idle_state", 64'(state_dbg), 0);
    check("idle_no_read", 64'(bus.pcie_bas_read), 0);

    // single burst of 4
    do_cfg(64'hdead_beef_0000_0000);
    exp_cmd(0, 4);
    set_tail(4);
    wait_drain("t1", 200);
    check("t1_head", 64'(head_ptr), 4);

    // advance to rd_ptr=124, then a tail past the wrap splits into two bursts
    for (int k = 0; k < 15; k++) exp_cmd(4 + 8 * k, 8);
    set_tail(124);
    wait_drain("t2a", 1000);
    check("t2a_head", 64'(head_ptr), 124);
    exp_cmd(124, 4);
    exp_cmd(0, 6);
    set_tail(6);
    wait_drain("t2b", 300);
    check("t2b_head", 64'(head_ptr), 6);

    // waitrequest held for 5 cycles
    acc0 = accepted;
    stall_left = 5;
    exp_cmd(6, 3);
    set_tail(9);
    wait_drain("t3a", 300);
    exp_cmd(9, 2);
    set_tail(11);
    wait_drain("t3b", 300);
    check("t3_accepts", 64'(accepted - acc0), 2);
    check("t3_head", 64'(head_ptr), 11);

    // backpressure: reservation caps in-flight plus buffered beats at 32
    do_cfg(64'h0000_0001_2345_0000);
    acc_beats = 0;
    popped = 0;
    max_res = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 12; k++) exp_cmd(8 * k, 8);
    exp_cmd(96, 4);
    set_tail(100);
    repeat (150) @(negedge pcie_clk);
    check("t4_reserved_beats", 64'(acc_beats), 32);
    check("t4_out_valid", 64'(bus.out_valid), 1);
    check("t4_head_stalled", 64'(head_ptr), 0);
    tick();
    bus.out_ready = 1'b1;
    wait_drain("t4", 2000);
    check("t4_max_reserved", 64'(max_res), 32);
    check("t4_head", 64'(head_ptr), 100);

    // error response on beat 2 of 4
    err_idx = 101;
    exp_cmd(100, 4);
    set_tail(104);
    wait_drain("t5", 300);
    err_idx = -1;
    check("t5_err_cnt", 64'(rd_err_cnt), 1);
    check("t5_head", 64'(head_ptr), 104);

    // async reset mid-burst
    do_cfg(64'h0000_0000_0040_0000);
    tick();
    bus.out_ready = 1'b0;
    exp_cmd(0, 8);
    acc0 = accepted;
    set_tail(8);
    n = 0;
    while (accepted == acc0 && n < 50) begin
      @(negedge pcie_clk);
      n++;
    end
    check("t6_cmd_seen", 64'(accepted - acc0), 1);
    @(posedge pcie_clk);
    @(posedge pcie_clk);
    #1 pcie_reset_n = 1'b0;
    exp_q.delete();
    #1 check_zero("t6_midrst");
    repeat (3) @(posedge pcie_clk);
    #1 pcie_reset_n = 1'b1;
    acc0 = accepted;
    repeat (30) @(negedge pcie_clk);
    check("t6_no_read", 64'(accepted - acc0), 0);
    check("t6_no_valid", 64'(bus.out_valid), 0);
    check("t6_state_idle", 64'(state_dbg), 0);
    check("t6_head", 64'(head_ptr), 0);
    tick();
    bus.out_ready = 1'b1;
    do_cfg(64'h0000_0000_0080_0000);
    exp_cmd(0, 2);
    set_tail(2);
    wait_drain("t6", 300);
    check("t6_recover_head", 64'(head_ptr), 2);
    check("cmd_queue_empty", 64'(exp_addr_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
